// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised line, mid-bit sampling from an
// oversample tick, optional parity, 1-2 stop bits, valid/ready frame output.
module uart_rx_os #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_os_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   wait_hi_q, wait_hi_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ovr_q, ovr_d;
  logic                   rx_s;
  logic                   mid;
  logic                   done;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign mid  = (tick_q == TW'(OVERSAMPLE - 1));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    wait_hi_d  = wait_hi_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_out_d = ferr_out_q;
    perr_out_d = perr_out_q;
    ovr_d      = ovr_q;
    done       = 1'b0;

    if (i_os_tick) begin
      case (state_q)
        S_IDLE: begin
          // After a low stop bit (e.g. break) the line must go high before a new start counts.
          if (wait_hi_q) begin
            if (rx_s) wait_hi_d = 1'b0;
          end else if (!rx_s) begin
            state_d = S_START;
            tick_d  = TW'(1);
          end
        end
        S_START: begin
          if (tick_q == TW'(OVERSAMPLE / 2)) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
              ferr_d  = 1'b0;
              perr_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (mid) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BW'(DATA_BITS - 1)) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (mid) begin
            tick_d  = '0;
            perr_d  = (PARITY == 1) ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (mid) begin
            tick_d = '0;
            if (!rx_s) ferr_d = 1'b1;
            // Leave mid stop bit so a start edge right after the stop bit is not missed.
            if (bit_q == BW'(STOP_BITS - 1)) begin
              done      = 1'b1;
              state_d   = S_IDLE;
              wait_hi_d = ~rx_s;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (done) begin
      if (!valid_q || i_ready) begin
        data_d     = shift_q;
        ferr_out_d = ferr_d;
        perr_out_d = perr_q;
        valid_d    = 1'b1;
        ovr_d      = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wait_hi_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_rx};
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      wait_hi_q  <= wait_hi_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_out_q <= ferr_out_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_out_q;
  assign o_parity_err = perr_out_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: one instance without parity, one with even parity,
// sharing clock, reset and an os tick every 4 clocks (64 clocks per bit).
module tb_uart_rx_os;
  localparam int BITCLK = 64;

  logic       clk = 1'b0;
  logic       rst, tick, rx0, rx2, rdy0, rdy2;
  logic [7:0] d0, d2;
  logic       v0, fe0, pe0, ov0, b0;
  logic       v2, fe2, pe2, ov2, b2;
  int         n_cmp = 0;
  int         n_err = 0;
  int         vcnt;
  logic [7:0] cap;

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_os_tick(tick), .i_rx(rx0), .o_data(d0), .o_valid(v0),
    .i_ready(rdy0), .o_frame_err(fe0), .o_parity_err(pe0), .o_overrun(ov0), .o_busy(b0));

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_os_tick(tick), .i_rx(rx2), .o_data(d2), .o_valid(v2),
    .i_ready(rdy2), .o_frame_err(fe2), .o_parity_err(pe2), .o_overrun(ov2), .o_busy(b2));

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int line, input logic b);
    if (line == 0) rx0 = b;
    else rx2 = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  // start, 8 data LSB first, stop, one idle bit
  task automatic send8(input logic [7:0] d, input logic stop);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
    drive_bit(0, stop);
    drive_bit(0, 1'b1);
  endtask

  task automatic send_par(input logic [7:0] d, input logic p);
    drive_bit(2, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(2, d[i]);
    drive_bit(2, p);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b1);
  endtask

  task automatic accept0();
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
  endtask

  task automatic accept2();
    rdy2 = 1'b1;
    @(negedge clk);
    rdy2 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_d;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h41, 1'b1, 8'h41, 1'b0};
    vecs[1] = '{8'h7A, 1'b1, 8'h7A, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 8'h55, 1'b1};
    vecs[3] = '{8'h20, 1'b1, 8'h20, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 8'hFF, 1'b0};

    rst = 1'b1; rx0 = 1'b1; rx2 = 1'b1; rdy0 = 1'b0; rdy2 = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_valid", {31'd0, v0}, 0);
    check("reset_data", {24'd0, d0}, 0);
    check("reset_busy", {31'd0, b0}, 0);
    check("reset_flags", {29'd0, fe0, pe0, ov0}, 0);
    rst = 1'b0;
    repeat (2 * BITCLK) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send8(vecs[i].din, vecs[i].stop);
      $display("frame %0d: sent %02h stop=%0b -> data %02h fe=%0b", i, vecs[i].din, vecs[i].stop, d0, fe0);
      check("vec_valid", {31'd0, v0}, 1);
      check("vec_data", {24'd0, d0}, {24'd0, vecs[i].exp_d});
      check("vec_ferr", {31'd0, fe0}, {31'd0, vecs[i].exp_fe});
      check("vec_perr_ovr", {30'd0, pe0, ov0}, 0);
      accept0();
      check("vec_release", {31'd0, v0}, 0);
    end

    // with i_ready held high the frame appears as a single-cycle pulse
    vcnt = 0; cap = 8'h00; rdy0 = 1'b1;
    fork
      send8(8'h7A, 1'b1);
      for (int k = 0; k < 11 * BITCLK; k++) begin
        @(negedge clk);
        if (v0) begin vcnt++; cap = d0; end
      end
    join
    rdy0 = 1'b0;
    $display("pulse: %0d valid cycles, data %02h", vcnt, cap);
    check("pulse_count", vcnt, 1);
    check("pulse_data", {24'd0, cap}, 32'h7A);

    // short low glitch must abort in START
    rx0 = 1'b0;
    repeat (16) @(negedge clk);
    check("glitch_busy", {31'd0, b0}, 1);
    rx0 = 1'b1;
    repeat (160) @(negedge clk);
    $display("glitch: busy=%0b valid=%0b", b0, v0);
    check("glitch_idle", {31'd0, b0}, 0);
    check("glitch_novalid", {31'd0, v0}, 0);

    send8(8'h61, 1'b1);
    send8(8'h62, 1'b1);
    $display("overrun: data %02h ovr=%0b", d0, ov0);
    check("ovr_valid", {31'd0, v0}, 1);
    check("ovr_data", {24'd0, d0}, 32'h61);
    check("ovr_flag", {31'd0, ov0}, 1);
    accept0();
    check("ovr_clr_valid", {31'd0, v0}, 0);
    check("ovr_clr_flag", {31'd0, ov0}, 0);

    // break: line low for 12 bit times
    rx0 = 1'b0;
    repeat (12 * BITCLK) @(negedge clk);
    $display("break: data %02h fe=%0b", d0, fe0);
    check("break_valid", {31'd0, v0}, 1);
    check("break_data", {24'd0, d0}, 0);
    check("break_ferr", {31'd0, fe0}, 1);
    accept0();
    repeat (3 * BITCLK) @(negedge clk);
    check("break_hold", {30'd0, v0, b0}, 0);
    rx0 = 1'b1;
    repeat (BITCLK) @(negedge clk);
    send8(8'h20, 1'b1);
    check("after_break", {23'd0, v0, d0, fe0}, {23'd0, 1'b1, 8'h20, 1'b0});
    accept0();

    send_par(8'h03, 1'b1);
    $display("parity 03/1: data %02h pe=%0b", d2, pe2);
    check("par_bad_valid", {31'd0, v2}, 1);
    check("par_bad_data", {24'd0, d2}, 32'h03);
    check("par_bad_err", {30'd0, pe2, fe2}, 32'h2);
    accept2();
    send_par(8'h03, 1'b0);
    $display("parity 03/0: data %02h pe=%0b", d2, pe2);
    check("par_ok_err", {30'd0, v2, pe2}, 32'h2);
    accept2();
    send_par(8'h07, 1'b1);
    $display("parity 07/1: data %02h pe=%0b", d2, pe2);
    check("par_ok2", {22'd0, v2, d2, pe2}, {22'd0, 1'b1, 8'h07, 1'b0});
    accept2();

    // reset in the middle of data bit 4 while a frame is held
    send8(8'h5A, 1'b1);
    check("pre_rst_valid", {31'd0, v0}, 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cap = 8'h33;
      drive_bit(0, cap[i]);
    end
    rx0 = 1'b1;
    repeat (BITCLK / 2) @(negedge clk);
    check("pre_rst_busy", {31'd0, b0}, 1);
    rst = 1'b1;
    #1;
    $display("mid reset: valid=%0b data %02h busy=%0b", v0, d0, b0);
    check("rst_outputs", {20'd0, v0, d0, b0, fe0, pe0, ov0}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * BITCLK) @(negedge clk);
    check("post_rst_quiet", {31'd0, v0}, 0);
    send8(8'h33, 1'b1);
    $display("after reset: data %02h", d0);
    check("post_rst_frame", {22'd0, v0, d0, fe0}, {22'd0, 1'b1, 8'h33, 1'b0});
    accept0();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
